// File: rtl/xtal_clk_ctrl.sv
// xtal_clk_ctrl: digital controller behind the crystal oscillator pad cell.
//
// Qualifies the raw oscillator clock with a warm-up count and then produces
// NUM_CH independently programmable divided clocks. Ratio changes are staged
// in shadow registers and adopted only at a falling toggle, so no runt pulse
// reaches the clock tree.
//
// Ports:
//   clk       raw oscillator clock (sole clock)
//   resetn    asynchronous active-low reset
//   en        oscillator enable; low forces the controller off
//   div_sel   half-period ratio per channel, ch i = div_sel[i*DIV_W +: DIV_W]
//   div_load  one-cycle strobe capturing div_sel into the shadow registers
//   ready     clock qualified (controller running)
//   clk_out   divided clocks, registered
//   busy      a shadow ratio is still pending on at least one channel
//   sync      phase-alignment pulse (only with XTAL_PHASE_SYNC_EN)
//
// Optional feature: define XTAL_PHASE_SYNC_EN to add the sync port. A sync
// pulse while running clears every channel counter, drives every clk_out low
// and adopts pending shadows on the next edge.
module xtal_clk_ctrl #(
  parameter int unsigned NUM_CH         = 2,
  parameter int unsigned DIV_W          = 4,
  parameter int unsigned STARTUP_CYCLES = 1024
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    en,
  input  logic [NUM_CH*DIV_W-1:0] div_sel,
  input  logic                    div_load,
  output logic                    ready,
  output logic [NUM_CH-1:0]       clk_out,
  output logic                    busy
`ifdef XTAL_PHASE_SYNC_EN
  ,
  input  logic                    sync
`endif
);

  localparam int unsigned WarmW = (STARTUP_CYCLES > 1) ? $clog2(STARTUP_CYCLES) : 1;
  localparam logic [WarmW-1:0] WarmLast = WarmW'(STARTUP_CYCLES - 1);
  localparam logic [WarmW-1:0] WarmOne  = WarmW'(1);
  localparam logic [DIV_W-1:0] DivOne   = DIV_W'(1);

  typedef enum logic [1:0] {StOff, StWarmup, StRun} state_e;

  state_e            state_q, state_d;
  logic [WarmW-1:0]  warm_q, warm_d;
  logic              ready_q, ready_d;

  logic [NUM_CH-1:0][DIV_W-1:0] cnt_q, cnt_d;
  logic [NUM_CH-1:0][DIV_W-1:0] act_q, act_d;
  logic [NUM_CH-1:0][DIV_W-1:0] shd_q, shd_d;
  logic [NUM_CH-1:0]            pnd_q, pnd_d;
  logic [NUM_CH-1:0]            out_q, out_d;

  logic run_q, run_d, sync_hit;

  // --------------------------------------------------------------------------
  // Warm-up FSM
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    warm_d  = warm_q;
    unique case (state_q)
      StOff: begin
        warm_d = '0;
        if (en) state_d = StWarmup;
      end
      StWarmup: begin
        if (!en) begin
          state_d = StOff;
          warm_d  = '0;
        end else if (warm_q == WarmLast) begin
          state_d = StRun;
          warm_d  = '0;
        end else begin
          warm_d = warm_q + WarmOne;
        end
      end
      StRun: begin
        warm_d = '0;
        if (!en) state_d = StOff;
      end
      default: begin
        state_d = StOff;
        warm_d  = '0;
      end
    endcase
  end

  assign run_q   = (state_q == StRun);
  assign run_d   = (state_d == StRun);
  // ready follows the next state so it rises on the same edge RUN is entered.
  assign ready_d = run_d;

`ifdef XTAL_PHASE_SYNC_EN
  assign sync_hit = sync && run_q;
`else
  assign sync_hit = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Divider channels
  // --------------------------------------------------------------------------
  always_comb begin
    cnt_d = cnt_q;
    act_d = act_q;
    shd_d = shd_q;
    pnd_d = pnd_q;
    out_d = out_q;
    for (int i = 0; i < NUM_CH; i++) begin
      if (!run_d) begin
        // Off or warming up (or leaving RUN): outputs parked low.
        cnt_d[i] = '0;
        out_d[i] = 1'b0;
      end else if (!run_q || sync_hit) begin
        // RUN entry or phase sync: restart from a known low phase.
        cnt_d[i] = '0;
        out_d[i] = 1'b0;
        if (pnd_q[i]) begin
          act_d[i] = shd_q[i];
          pnd_d[i] = 1'b0;
        end
      end else if (act_q[i] == '0) begin
        // Idle channel: output already low, so a new ratio is safe at once.
        cnt_d[i] = '0;
        out_d[i] = 1'b0;
        if (pnd_q[i]) begin
          act_d[i] = shd_q[i];
          pnd_d[i] = 1'b0;
        end
      end else if (cnt_q[i] == act_q[i] - DivOne) begin
        cnt_d[i] = '0;
        out_d[i] = ~out_q[i];
        // Only switch ratio at the falling toggle so the high phase completes.
        if (out_q[i] && pnd_q[i]) begin
          act_d[i] = shd_q[i];
          pnd_d[i] = 1'b0;
        end
      end else begin
        cnt_d[i] = cnt_q[i] + DivOne;
      end

      // A load on an adoption edge lands after it: the old shadow was taken,
      // the new one stays pending for the next falling toggle.
      if (div_load && !sync_hit) begin
        shd_d[i] = div_sel[i*DIV_W +: DIV_W];
        pnd_d[i] = 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= StOff;
      warm_q  <= '0;
      ready_q <= 1'b0;
      cnt_q   <= '0;
      act_q   <= '0;
      shd_q   <= '0;
      pnd_q   <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      warm_q  <= warm_d;
      ready_q <= ready_d;
      cnt_q   <= cnt_d;
      act_q   <= act_d;
      shd_q   <= shd_d;
      pnd_q   <= pnd_d;
      out_q   <= out_d;
    end
  end

  assign ready   = ready_q;
  assign clk_out = out_q;
  assign busy    = |pnd_q;

endmodule

// File: tb/tb_xtal_clk_ctrl.sv
// Testbench for xtal_clk_ctrl. The reference model tracks each channel as an
// arithmetic waveform: a segment start time and ratio r, with the output level
// given by floor(elapsed / r) mod 2.
module tb_xtal_clk_ctrl;

  localparam int S   = 16;
  localparam int NCH = 2;
  localparam int DW  = 4;

  logic              clk = 1'b0;
  logic              resetn = 1'b0;
  logic              en = 1'b0;
  logic              div_load = 1'b0;
  logic [NCH*DW-1:0] div_sel = '0;
  logic              ready;
  logic [NCH-1:0]    clk_out;
  logic              busy;
`ifdef XTAL_PHASE_SYNC_EN
  logic              sync = 1'b0;
`endif

  bit clk_run = 1'b1;
  always begin
    #5;
    if (clk_run) clk = ~clk;
  end

  xtal_clk_ctrl #(
    .NUM_CH        (NCH),
    .DIV_W         (DW),
    .STARTUP_CYCLES(S)
  ) dut (
    .clk     (clk),
    .resetn  (resetn),
    .en      (en),
    .div_sel (div_sel),
    .div_load(div_load),
    .ready   (ready),
    .clk_out (clk_out),
    .busy    (busy)
`ifdef XTAL_PHASE_SYNC_EN
    ,
    .sync    (sync)
`endif
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: 0 = off, 1 = warming up, 2 = running.
  int m_state;
  int m_wstart;
  int m_now;
  int m_act   [NCH];
  int m_shd   [NCH];
  int m_start [NCH];
  bit m_pnd   [NCH];

  function automatic void model_reset();
    m_state  = 0;
    m_wstart = 0;
    for (int c = 0; c < NCH; c++) begin
      m_act[c]   = 0;
      m_shd[c]   = 0;
      m_start[c] = 0;
      m_pnd[c]   = 1'b0;
    end
  endfunction

  function automatic void adopt(input int c);
    m_act[c]   = m_shd[c];
    m_pnd[c]   = 1'b0;
    m_start[c] = m_now;
  endfunction

  function automatic void model_edge(input bit e, input bit ld, input logic [NCH*DW-1:0] sel);
    int prev;
    int el;
    m_now++;
    prev = m_state;
    if (!e) m_state = 0;
    else if (m_state == 0) begin
      m_state  = 1;
      m_wstart = m_now;
    end else if (m_state == 1 && m_now - m_wstart == S) m_state = 2;
    for (int c = 0; c < NCH; c++) begin
      if (m_state == 2) begin
        if (prev != 2) begin
          if (m_pnd[c]) adopt(c);
          m_start[c] = m_now;
        end else begin
          el = m_now - m_start[c];
          if (m_pnd[c] && (m_act[c] == 0 || (el > 0 && el % (2 * m_act[c]) == 0))) adopt(c);
        end
      end
      if (ld) begin
        m_shd[c] = int'(sel[c*DW +: DW]);
        m_pnd[c] = 1'b1;
      end
    end
  endfunction

  function automatic int exp_out(input int c);
    if (m_state == 2 && m_act[c] > 0) return ((m_now - m_start[c]) / m_act[c]) % 2;
    return 0;
  endfunction

  function automatic int exp_busy();
    for (int c = 0; c < NCH; c++) if (m_pnd[c]) return 1;
    return 0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv)
    else begin
      n_err++;
      $error("FAIL %s at cycle %0d: observed %0d expected %0d", tag, m_now, obs, expv);
    end
  endtask

  task automatic check_all(input string ph);
    chk({ph, ".ready"}, 32'(ready), 32'(m_state == 2));
    chk({ph, ".busy"}, 32'(busy), 32'(exp_busy()));
    for (int c = 0; c < NCH; c++)
      chk($sformatf("%s.clk_out%0d", ph, c), 32'(clk_out[c]), 32'(exp_out(c)));
  endtask

  task automatic step(input string ph, input bit e, input bit ld,
                      input logic [NCH*DW-1:0] sel);
    @(negedge clk);
    en       = e;
    div_load = ld;
    div_sel  = sel;
    @(posedge clk);
    model_edge(e, ld, sel);
    #1;
    check_all(ph);
  endtask

  initial begin
    logic [NCH*DW-1:0] sel;
    model_reset();
    m_now = 0;

    // Reset state
    #1;
    check_all("reset");
    @(negedge clk);
    resetn = 1'b1;

    // Ratios 3 / 1 loaded while off, then warm-up and run
    step("load_off", 1'b0, 1'b1, {4'd1, 4'd3});
    for (int k = 0; k < 50; k++) step("startup", 1'b1, 1'b0, '0);

    // ch0 r=4, then r=1 requested in the middle of a high phase
    step("load4", 1'b1, 1'b1, {4'd1, 4'd4});
    for (int k = 0; k < 20; k++) step("run4", 1'b1, 1'b0, '0);
    for (int k = 0; k < 10 && exp_out(0) == 0; k++) step("seek_high", 1'b1, 1'b0, '0);
    step("load1", 1'b1, 1'b1, {4'd1, 4'd1});
    for (int k = 0; k < 20; k++) step("run1", 1'b1, 1'b0, '0);

    // Enable dropped at warm-up count 10, then a full warm-up again
    for (int k = 0; k < 3; k++) step("off", 1'b0, 1'b0, '0);
    for (int k = 0; k < 11; k++) step("warm_a", 1'b1, 1'b0, '0);
    step("drop", 1'b0, 1'b0, '0);
    for (int k = 0; k < 30; k++) step("warm_b", 1'b1, 1'b0, '0);

    // Randomized operation
    for (int k = 0; k < 2500; k++) begin
      sel = NCH*DW'($urandom);
      step("rand", ($urandom_range(0, 99) != 0), ($urandom_range(0, 7) == 0), sel);
    end

    // Asynchronous reset in RUN with the clock stalled
    step("pre_rst", 1'b1, 1'b1, {4'd2, 4'd5});
    for (int k = 0; k < 40 && m_state != 2; k++) step("to_run", 1'b1, 1'b0, '0);
    for (int k = 0; k < 7; k++) step("run_rst", 1'b1, 1'b0, '0);
    clk_run = 1'b0;
    #3;
    resetn = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    #10;
    resetn  = 1'b1;
    clk_run = 1'b1;
    for (int k = 0; k < 30; k++) step("post_rst", 1'b1, 1'b0, '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
